// File: rtl/cplx_cond_neg_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cplx_cond_neg_pipe
//  Description : Pipelined per-beat complex conditional negation over NUM_CH
//                packed lanes. Modes: pass, negate, conjugate, multiply by j.
//                Flags the -2^(W-1) negation case per beat and keeps a
//                saturating count of flagged beats. One register stage with
//                valid/ready flow control.
//                Optional macro COMP2S_SAT_EN: an overflowing negation
//                saturates to +2^(W-1)-1 instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module cplx_cond_neg_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [1:0]                     i_mode,
    input  logic [2*DATA_WIDTH*NUM_CH-1:0] i_din,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [2*DATA_WIDTH*NUM_CH-1:0] o_dout,
    output logic                           o_ovf,
    input  logic                           i_cnt_clr,
    output logic [CNT_WIDTH-1:0]           o_ovf_cnt
);

    localparam int                    c_W       = DATA_WIDTH;
    localparam int                    c_BEAT_W  = 2 * DATA_WIDTH * NUM_CH;
    localparam logic [c_W-1:0]        c_MIN     = {1'b1, {(c_W-1){1'b0}}};
    localparam logic [c_W-1:0]        c_MAX     = {1'b0, {(c_W-1){1'b1}}};
    localparam logic [c_W-1:0]        c_ONE     = c_W'(1);
    localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE = CNT_WIDTH'(1);

    localparam logic [1:0] c_MODE_PASS = 2'd0;
    localparam logic [1:0] c_MODE_NEG  = 2'd1;
    localparam logic [1:0] c_MODE_CONJ = 2'd2;
    localparam logic [1:0] c_MODE_MULJ = 2'd3;

    // Two's-complement negation; the most negative value either wraps onto
    // itself or, in the saturating build, clamps to the most positive value.
    function automatic logic [c_W-1:0] f_neg(input logic [c_W-1:0] x);
`ifdef COMP2S_SAT_EN
        if (x == c_MIN) begin
            return c_MAX;
        end
        return (~x) + c_ONE;
`else
        return (~x) + c_ONE;
`endif
    endfunction

    logic [c_BEAT_W-1:0]  w_res;
    logic [NUM_CH-1:0]    w_lane_ovf;
    logic                 w_ovf;
    logic                 w_accept;

    logic                 r_valid;
    logic [c_BEAT_W-1:0]  r_dout;
    logic                 r_ovf;
    logic [CNT_WIDTH-1:0] r_cnt;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
            logic [c_W-1:0] w_re;
            logic [c_W-1:0] w_im;
            logic [c_W-1:0] w_out_re;
            logic [c_W-1:0] w_out_im;
            logic           w_ovf_l;
            logic           w_re_min;
            logic           w_im_min;

            assign w_re     = i_din[2*c_W*k +: c_W];
            assign w_im     = i_din[2*c_W*k + c_W +: c_W];
            assign w_re_min = (w_re == c_MIN);
            assign w_im_min = (w_im == c_MIN);

            // Per-lane mode mux; only components that are actually negated
            // may raise the overflow flag.
            always_comb begin
                w_out_re = w_re;
                w_out_im = w_im;
                w_ovf_l  = 1'b0;
                case (i_mode)
                    c_MODE_PASS: begin
                        w_out_re = w_re;
                        w_out_im = w_im;
                        w_ovf_l  = 1'b0;
                    end
                    c_MODE_NEG: begin
                        w_out_re = f_neg(w_re);
                        w_out_im = f_neg(w_im);
                        w_ovf_l  = w_re_min | w_im_min;
                    end
                    c_MODE_CONJ: begin
                        w_out_re = w_re;
                        w_out_im = f_neg(w_im);
                        w_ovf_l  = w_im_min;
                    end
                    c_MODE_MULJ: begin
                        w_out_re = f_neg(w_im);
                        w_out_im = w_re;
                        w_ovf_l  = w_im_min;
                    end
                    default: begin
                        w_out_re = w_re;
                        w_out_im = w_im;
                        w_ovf_l  = 1'b0;
                    end
                endcase
            end

            assign w_res[2*c_W*k +: 2*c_W] = {w_out_im, w_out_re};
            assign w_lane_ovf[k]           = w_ovf_l;
        end
    endgenerate

    assign w_ovf    = |w_lane_ovf;
    assign o_ready  = ~r_valid | i_ready;
    assign w_accept = i_valid & o_ready;

    // Output stage: load on accept, drain when downstream takes without a
    // replacement, otherwise hold the beat stable.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_dout  <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_dout  <= w_res;
            r_ovf   <= w_ovf;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating count of accepted overflow beats; clear beats increment.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_accept && w_ovf && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    assign o_valid   = r_valid;
    assign o_dout    = r_dout;
    assign o_ovf     = r_ovf;
    assign o_ovf_cnt = r_cnt;

endmodule
`default_nettype wire
